// File: rtl/gb_apu_pkg.sv
// gb_apu_pkg: register addresses, readback masks and trigger stretcher states shared by the pulse register file.
package gb_apu_pkg;
    localparam logic [7:0] NR10_ADDR = 8'h10;
    localparam logic [7:0] NR11_ADDR = 8'h11;
    localparam logic [7:0] NR12_ADDR = 8'h12;
    localparam logic [7:0] NR13_ADDR = 8'h13;
    localparam logic [7:0] NR14_ADDR = 8'h14;
    localparam logic [7:0] NR21_ADDR = 8'h16;
    localparam logic [7:0] NR22_ADDR = 8'h17;
    localparam logic [7:0] NR23_ADDR = 8'h18;
    localparam logic [7:0] NR24_ADDR = 8'h19;
    localparam logic [7:0] NR52_ADDR = 8'h26;
    localparam logic [7:0] NR10_MASK = 8'h80;
    localparam logic [7:0] NRX1_MASK = 8'h3F;
    localparam logic [7:0] NRX2_MASK = 8'h00;
    localparam logic [7:0] NRX3_MASK = 8'hFF;
    localparam logic [7:0] NRX4_MASK = 8'hBF;
    localparam logic [7:0] NR52_MASK = 8'h70;
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} stretch_state_e;
endpackage

// File: rtl/gb_triggerStretcher.sv
// gb_triggerStretcher: stretches a one-cycle trigger request into a START_CYCLES-wide start pulse
// followed by at least START_GAP low cycles; requests arriving mid-pulse collapse into one pending retrigger.
module gb_triggerStretcher import gb_apu_pkg::*; #(
    parameter int START_CYCLES = 2,
    parameter int START_GAP    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic req,
    output logic start
);
    localparam int MAXC = (START_CYCLES > START_GAP) ? START_CYCLES : START_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    stretch_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pending_q, pending_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = req ? ST_HIGH : ST_IDLE;
            end
            ST_HIGH: begin
                pending_d = pending_q | req;
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                pending_d = pending_q | req;
                if (cnt_q == CW'(START_GAP - 1)) begin
                    state_d   = (pending_q | req) ? ST_HIGH : ST_IDLE;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pending_d = 1'b0;
        end
    end
    always_comb start = (state_q == ST_HIGH);
endmodule

// File: rtl/gb_pulse_regfile.sv
// gb_pulse_regfile: CPU register file for pulse channels 1/2 and NR52 power control.
// Define GB_PULSE_READMASK_EN to OR write-only bits to 1 on readback; otherwise raw stored bits are returned.
module gb_pulse_regfile import gb_apu_pkg::*; #(
    parameter int START_CYCLES = 2,
    parameter int START_GAP    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        ch1_enable,
    input  logic        ch2_enable,
    output logic [2:0]  ch1_sweep_time,
    output logic        ch1_sweep_decreasing,
    output logic [2:0]  ch1_num_sweep_shifts,
    output logic [1:0]  ch1_wave_duty,
    output logic [5:0]  ch1_length,
    output logic [3:0]  ch1_initial_volume,
    output logic        ch1_envelope_increasing,
    output logic [2:0]  ch1_num_envelope_sweeps,
    output logic [10:0] ch1_frequency,
    output logic        ch1_single,
    output logic        ch1_start,
    output logic [1:0]  ch2_wave_duty,
    output logic [5:0]  ch2_length,
    output logic [3:0]  ch2_initial_volume,
    output logic        ch2_envelope_increasing,
    output logic [2:0]  ch2_num_envelope_sweeps,
    output logic [10:0] ch2_frequency,
    output logic        ch2_single,
    output logic        ch2_start,
    output logic        apu_power
);
`ifdef GB_PULSE_READMASK_EN
    localparam logic [7:0] MASK_SEL = 8'hFF;
`else
    localparam logic [7:0] MASK_SEL = 8'h00;
`endif
    logic [6:0] nr10_q, nr10_d;
    logic [7:0] nr11_q, nr11_d, nr12_q, nr12_d, nr13_q, nr13_d;
    logic [7:0] nr21_q, nr21_d, nr22_q, nr22_d, nr23_q, nr23_d;
    logic [3:0] nr14_q, nr14_d, nr24_q, nr24_d;
    logic       power_q, power_d, rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d, rd_mux;
    logic       wr_ok, power_off, trig1, trig2;
    always_comb begin
        wr_ok      = wr_en && (power_q || addr == NR52_ADDR);
        power_off  = wr_ok && addr == NR52_ADDR && power_q && !wr_data[7];
        trig1      = wr_ok && addr == NR14_ADDR && wr_data[7];
        trig2      = wr_ok && addr == NR24_ADDR && wr_data[7];
        power_d    = (wr_ok && addr == NR52_ADDR) ? wr_data[7] : power_q;
        nr10_d     = power_off ? '0 : (wr_ok && addr == NR10_ADDR) ? wr_data[6:0] : nr10_q;
        nr11_d     = power_off ? '0 : (wr_ok && addr == NR11_ADDR) ? wr_data : nr11_q;
        nr12_d     = power_off ? '0 : (wr_ok && addr == NR12_ADDR) ? wr_data : nr12_q;
        nr13_d     = power_off ? '0 : (wr_ok && addr == NR13_ADDR) ? wr_data : nr13_q;
        nr14_d     = power_off ? '0 : (wr_ok && addr == NR14_ADDR) ? {wr_data[6], wr_data[2:0]} : nr14_q;
        nr21_d     = power_off ? '0 : (wr_ok && addr == NR21_ADDR) ? wr_data : nr21_q;
        nr22_d     = power_off ? '0 : (wr_ok && addr == NR22_ADDR) ? wr_data : nr22_q;
        nr23_d     = power_off ? '0 : (wr_ok && addr == NR23_ADDR) ? wr_data : nr23_q;
        nr24_d     = power_off ? '0 : (wr_ok && addr == NR24_ADDR) ? {wr_data[6], wr_data[2:0]} : nr24_q;
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_mux : rd_data_q;
    end
    // Mux reads the current flop values, so a same-cycle write is not visible until the next read.
    always_comb begin
        case (addr)
            NR10_ADDR: rd_mux = {1'b0, nr10_q} | (NR10_MASK & MASK_SEL);
            NR11_ADDR: rd_mux = nr11_q | (NRX1_MASK & MASK_SEL);
            NR12_ADDR: rd_mux = nr12_q | (NRX2_MASK & MASK_SEL);
            NR13_ADDR: rd_mux = nr13_q | (NRX3_MASK & MASK_SEL);
            NR14_ADDR: rd_mux = {1'b0, nr14_q[3], 3'b000, nr14_q[2:0]} | (NRX4_MASK & MASK_SEL);
            NR21_ADDR: rd_mux = nr21_q | (NRX1_MASK & MASK_SEL);
            NR22_ADDR: rd_mux = nr22_q | (NRX2_MASK & MASK_SEL);
            NR23_ADDR: rd_mux = nr23_q | (NRX3_MASK & MASK_SEL);
            NR24_ADDR: rd_mux = {1'b0, nr24_q[3], 3'b000, nr24_q[2:0]} | (NRX4_MASK & MASK_SEL);
            NR52_ADDR: rd_mux = {power_q, 5'b00000, ch2_enable, ch1_enable} | (NR52_MASK & MASK_SEL);
            default:   rd_mux = 8'hFF;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nr10_q     <= '0;
            nr11_q     <= '0;
            nr12_q     <= '0;
            nr13_q     <= '0;
            nr14_q     <= '0;
            nr21_q     <= '0;
            nr22_q     <= '0;
            nr23_q     <= '0;
            nr24_q     <= '0;
            power_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            nr10_q     <= nr10_d;
            nr11_q     <= nr11_d;
            nr12_q     <= nr12_d;
            nr13_q     <= nr13_d;
            nr14_q     <= nr14_d;
            nr21_q     <= nr21_d;
            nr22_q     <= nr22_d;
            nr23_q     <= nr23_d;
            nr24_q     <= nr24_d;
            power_q    <= power_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
    gb_triggerStretcher #(.START_CYCLES(START_CYCLES), .START_GAP(START_GAP)) u_str1 (
        .clk(clk), .reset(reset), .clear(power_off), .req(trig1), .start(ch1_start)
    );
    gb_triggerStretcher #(.START_CYCLES(START_CYCLES), .START_GAP(START_GAP)) u_str2 (
        .clk(clk), .reset(reset), .clear(power_off), .req(trig2), .start(ch2_start)
    );
    assign rd_data                 = rd_data_q;
    assign rd_valid                = rd_valid_q;
    assign apu_power               = power_q;
    assign ch1_sweep_time          = nr10_q[6:4];
    assign ch1_sweep_decreasing    = nr10_q[3];
    assign ch1_num_sweep_shifts    = nr10_q[2:0];
    assign ch1_wave_duty           = nr11_q[7:6];
    assign ch1_length              = nr11_q[5:0];
    assign ch1_initial_volume      = nr12_q[7:4];
    assign ch1_envelope_increasing = nr12_q[3];
    assign ch1_num_envelope_sweeps = nr12_q[2:0];
    assign ch1_frequency           = {nr14_q[2:0], nr13_q};
    assign ch1_single              = nr14_q[3];
    assign ch2_wave_duty           = nr21_q[7:6];
    assign ch2_length              = nr21_q[5:0];
    assign ch2_initial_volume      = nr22_q[7:4];
    assign ch2_envelope_increasing = nr22_q[3];
    assign ch2_num_envelope_sweeps = nr22_q[2:0];
    assign ch2_frequency           = {nr24_q[2:0], nr23_q};
    assign ch2_single              = nr24_q[3];
endmodule

// File: tb/tb_gb_pulse_regfile.sv
// tb_gb_pulse_regfile: directed checks of register decode, readback masking, trigger stretching and power-off.
module tb_gb_pulse_regfile;
`ifdef GB_PULSE_READMASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  addr = '0, wr_data = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0, ch1_enable = 1'b0, ch2_enable = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid, apu_power;
    logic [2:0]  ch1_sweep_time, ch1_num_sweep_shifts, ch1_num_envelope_sweeps, ch2_num_envelope_sweeps;
    logic        ch1_sweep_decreasing, ch1_envelope_increasing, ch2_envelope_increasing;
    logic [1:0]  ch1_wave_duty, ch2_wave_duty;
    logic [5:0]  ch1_length, ch2_length;
    logic [3:0]  ch1_initial_volume, ch2_initial_volume;
    logic [10:0] ch1_frequency, ch2_frequency;
    logic        ch1_single, ch2_single, ch1_start, ch2_start;
    int checks = 0, errors = 0;
    int rises2 = 0, low_run = 0, last_gap = 0;
    logic prev2 = 1'b0;
    logic [7:0] r;
    int cnt, r0;
    always #5 clk = ~clk;
    gb_pulse_regfile dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .ch1_enable(ch1_enable), .ch2_enable(ch2_enable),
        .ch1_sweep_time(ch1_sweep_time), .ch1_sweep_decreasing(ch1_sweep_decreasing),
        .ch1_num_sweep_shifts(ch1_num_sweep_shifts), .ch1_wave_duty(ch1_wave_duty), .ch1_length(ch1_length),
        .ch1_initial_volume(ch1_initial_volume), .ch1_envelope_increasing(ch1_envelope_increasing),
        .ch1_num_envelope_sweeps(ch1_num_envelope_sweeps), .ch1_frequency(ch1_frequency),
        .ch1_single(ch1_single), .ch1_start(ch1_start), .ch2_wave_duty(ch2_wave_duty), .ch2_length(ch2_length),
        .ch2_initial_volume(ch2_initial_volume), .ch2_envelope_increasing(ch2_envelope_increasing),
        .ch2_num_envelope_sweeps(ch2_num_envelope_sweeps), .ch2_frequency(ch2_frequency),
        .ch2_single(ch2_single), .ch2_start(ch2_start), .apu_power(apu_power)
    );
    // Rising-edge counter on ch2_start, recording the low run that preceded each rise.
    always @(negedge clk) begin
        if (ch2_start && !prev2) begin
            rises2++;
            last_gap = low_run;
        end
        low_run = ch2_start ? 0 : low_run + 1;
        prev2 = ch2_start;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        wr_data = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask
    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        addr = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("rd_valid", rd_valid, 1);
        v = rd_data;
    endtask
    initial begin
        @(posedge clk);
        #1;
        chk("rst_power", apu_power, 0);
        chk("rst_start", {ch1_start, ch2_start}, 0);
        chk("rst_rd_valid", rd_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(8'h10, r); chk("rst_nr10", r, MASK ? 8'h80 : 8'h00);
        rd(8'h11, r); chk("rst_nr11", r, MASK ? 8'h3F : 8'h00);
        rd(8'h14, r); chk("rst_nr14", r, MASK ? 8'hBF : 8'h00);
        rd(8'h26, r); chk("rst_nr52", r, MASK ? 8'h70 : 8'h00);
        rd(8'h15, r); chk("unmapped_15", r, 8'hFF);
        @(negedge clk);
        chk("rd_valid_drop", rd_valid, 0);
        wr(8'h26, 8'h80);
        chk("power_on", apu_power, 1);
        wr(8'h13, 8'h56);
        chk("ch1_start_pre", ch1_start, 0);
        wr(8'h14, 8'hC3);
        chk("ch1_freq", ch1_frequency, 11'h356);
        chk("ch1_single", ch1_single, 1);
        chk("ch1_start_first", ch1_start, 1);
        cnt = ch1_start;
        repeat (7) begin
            @(negedge clk);
            cnt += ch1_start;
        end
        chk("ch1_start_width", cnt, 2);
        rd(8'h14, r); chk("rd_nr14", r, MASK ? 8'hFF : 8'h43);
        rd(8'h13, r); chk("rd_nr13", r, MASK ? 8'hFF : 8'h56);
        r0 = rises2;
        wr(8'h19, 8'h80);
        wr(8'h19, 8'h80);
        wr(8'h19, 8'h80);
        repeat (16) @(negedge clk);
        chk("ch2_rises", rises2 - r0, 2);
        chk("ch2_gap", last_gap, 1);
        chk("ch2_freq", ch2_frequency, 0);
        wr(8'h11, 8'hC5);
        chk("ch1_duty", ch1_wave_duty, 3);
        chk("ch1_length", ch1_length, 5);
        wr(8'h12, 8'hF3);
        chk("ch1_vol", ch1_initial_volume, 4'hF);
        wr(8'h14, 8'h80);
        chk("ch1_start_retrig", ch1_start, 1);
        wr(8'h26, 8'h00);
        chk("off_start", ch1_start, 0);
        chk("off_power", apu_power, 0);
        chk("off_ch1_regs", {ch1_sweep_time, ch1_sweep_decreasing, ch1_num_sweep_shifts, ch1_wave_duty,
            ch1_length, ch1_initial_volume, ch1_envelope_increasing, ch1_num_envelope_sweeps,
            ch1_frequency, ch1_single}, 0);
        chk("off_ch2_regs", {ch2_wave_duty, ch2_length, ch2_initial_volume, ch2_envelope_increasing,
            ch2_num_envelope_sweeps, ch2_frequency, ch2_single}, 0);
        wr(8'h12, 8'hF3);
        chk("off_wr_ignored", ch1_initial_volume, 0);
        rd(8'h12, r); chk("off_rd_nr12", r, 8'h00);
        rd(8'h11, r); chk("off_rd_nr11", r, MASK ? 8'h3F : 8'h00);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cnt += ch1_start;
        end
        chk("off_no_start", cnt, 0);
        ch1_enable = 1'b1;
        ch2_enable = 1'b0;
        wr(8'h26, 8'h80);
        rd(8'h26, r); chk("rd_nr52_en", r, MASK ? 8'hF1 : 8'h81);
        wr(8'h17, 8'hA2);
        chk("ch2_vol", ch2_initial_volume, 4'hA);
        chk("ch2_sweeps", ch2_num_envelope_sweeps, 2);
        addr = 8'h17;
        wr_data = 8'h5B;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw_same_old", rd_data, 8'hA2);
        chk("rw_same_vol", ch2_initial_volume, 4'h5);
        chk("rw_same_inc", ch2_envelope_increasing, 1);
        rd(8'h17, r); chk("rw_same_new", r, 8'h5B);
        wr(8'h14, 8'h80);
        chk("stretch_hi", ch1_start, 1);
        addr = 8'h26;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", rd_valid, 1);
        chk("pre_rst_start", ch1_start, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rd_valid", rd_valid, 0);
        chk("async_rd_data", rd_data, 0);
        chk("async_start", ch1_start, 0);
        chk("async_power", apu_power, 0);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += ch1_start + rd_valid;
        end
        chk("post_rst_quiet", cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
